contador_equilibrio: RTL and testbench

- Bidirectional position counter for the balance game.
- Starts at the centre point M/2-1 and is pushed up or down by player inputs.
- Drifts back toward centre when left alone, and locks when either end (0 or M-1) is reached.
- It is the two-way counterpart of the team's up-only half-range counter and feeds the score/display logic with end and centre flags.

---
 rtl/contador_equilibrio.sv | 138 +++++++++++++
 tb/tb_contador_equilibrio.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_equilibrio.sv
// contador_equilibrio: bidirectional position counter for the balance game.
//
// The position starts at the centre (M/2-1), is pushed up or down one step per
// cycle by the players, drifts back toward centre after DECAY idle cycles and
// locks once either end (0 or M-1) is reached.
//
// Ports:
//   clock     in   system clock, rising edge
//   zera_as   in   asynchronous active-high reset
//   zera_s    in   synchronous clear, same result as reset, highest priority
//   inicia    in   start (PARADO->ATIVO) / release (TRAVADO->PARADO)
//   sobe      in   step-up request
//   desce     in   step-down request
//   Q         out  current position (N bits)
//   fim_alto  out  Q == M-1
//   fim_baixo out  Q == 0
//   meio      out  Q == M/2-1
//   travado   out  state is TRAVADO
//   estado    out  state code: PARADO=00, ATIVO=01, TRAVADO=10
module contador_equilibrio #(
    parameter int unsigned M     = 100,
    parameter int unsigned N     = 7,
    parameter int unsigned DECAY = 50,
    parameter int unsigned DW    = 6
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         inicia,
    input  logic         sobe,
    input  logic         desce,
    output logic [N-1:0] Q,
    output logic         fim_alto,
    output logic         fim_baixo,
    output logic         meio,
    output logic         travado,
    output logic [1:0]   estado
);

    localparam logic [N-1:0]  Centre    = N'(M / 2 - 1);
    localparam logic [N-1:0]  Top       = N'(M - 1);
    localparam logic [DW-1:0] DecayLast = DW'(DECAY - 1);

    typedef enum logic [1:0] {
        StParado  = 2'b00,
        StAtivo   = 2'b01,
        StTravado = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [DW-1:0] drift_q, drift_d;

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            state_q <= StParado;
            q_q     <= Centre;
            drift_q <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            drift_q <= drift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        drift_d = drift_q;

        if (zera_s) begin
            state_d = StParado;
            q_d     = Centre;
            drift_d = '0;
        end else begin
            case (state_q)
                StParado: begin
                    q_d     = Centre;
                    drift_d = '0;
                    if (inicia) begin
                        state_d = StAtivo;
                    end
                end

                StAtivo: begin
                    if (sobe ^ desce) begin
                        // Exactly one player pushing: saturating step, drift restarts.
                        drift_d = '0;
                        if (sobe) begin
                            q_d = (q_q == Top) ? q_q : q_q + 1'b1;
                        end else begin
                            q_d = (q_q == '0) ? q_q : q_q - 1'b1;
                        end
                    end else if (drift_q == DecayLast) begin
                        // Idle long enough: one step toward centre. Since the step is
                        // toward centre it can never land on an end.
                        drift_d = '0;
                        if (q_q > Centre) begin
                            q_d = q_q - 1'b1;
                        end else if (q_q < Centre) begin
                            q_d = q_q + 1'b1;
                        end
                    end else begin
                        drift_d = drift_q + 1'b1;
                    end

                    // Lock on the same edge that Q arrives at an end.
                    if ((q_d == Top) || (q_d == '0)) begin
                        state_d = StTravado;
                    end
                end

                StTravado: begin
                    if (inicia) begin
                        state_d = StParado;
                        q_d     = Centre;
                        drift_d = '0;
                    end
                end

                default: begin
                    // Unused code 11 recovers to a clean PARADO.
                    state_d = StParado;
                    q_d     = Centre;
                    drift_d = '0;
                end
            endcase
        end
    end

    assign Q         = q_q;
    assign fim_alto  = (q_q == Top);
    assign fim_baixo = (q_q == '0);
    assign meio      = (q_q == Centre);
    assign travado   = (state_q == StTravado);
    assign estado    = state_q;

endmodule

// File: tb/tb_contador_equilibrio.sv
// Testbench for contador_equilibrio (M=100, DECAY=4).
module tb_contador_equilibrio;

    localparam int M     = 100;
    localparam int N     = 7;
    localparam int DECAY = 4;
    localparam int DW    = 3;
    localparam int C     = M / 2 - 1;

    logic         clock = 1'b0;
    logic         zera_as = 1'b0;
    logic         zera_s = 1'b0;
    logic         inicia = 1'b0;
    logic         sobe = 1'b0;
    logic         desce = 1'b0;
    logic [N-1:0] Q;
    logic         fim_alto, fim_baixo, meio, travado;
    logic [1:0]   estado;

    int checks = 0;
    int failures = 0;

    contador_equilibrio #(
        .M    (M),
        .N    (N),
        .DECAY(DECAY),
        .DW   (DW)
    ) dut (
        .clock    (clock),
        .zera_as  (zera_as),
        .zera_s   (zera_s),
        .inicia   (inicia),
        .sobe     (sobe),
        .desce    (desce),
        .Q        (Q),
        .fim_alto (fim_alto),
        .fim_baixo(fim_baixo),
        .meio     (meio),
        .travado  (travado),
        .estado   (estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        inicia  = 1'b0;
        sobe    = 1'b0;
        desce   = 1'b0;
        zera_s  = 1'b0;
        zera_as = 1'b1;
        #2;
        zera_as = 1'b0;
        #1;
    endtask

    task automatic start_game();
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
    endtask

    task automatic test_reset();
        inicia  = 1'b0;
        sobe    = 1'b0;
        desce   = 1'b0;
        zera_as = 1'b1;
        #2;
        checks++;
        if (Q !== 7'd49 || meio !== 1'b1 || estado !== 2'b00 || fim_alto !== 1'b0
            || fim_baixo !== 1'b0 || travado !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: Q=%0d meio=%b estado=%b fa=%b fb=%b tr=%b, want 49 1 00 0 0 0",
                     Q, meio, estado, fim_alto, fim_baixo, travado);
        end
        zera_as = 1'b0;
        sobe    = 1'b1;
        repeat (10) tick();
        sobe = 1'b0;
        checks++;
        if (Q !== 7'd49 || estado !== 2'b00) begin
            failures++;
            $display("FAIL parado_ignores_sobe: Q=%0d estado=%b, want 49 00", Q, estado);
        end
    endtask

    task automatic test_climb();
        do_reset();
        start_game();
        checks++;
        if (estado !== 2'b01 || Q !== 7'd49) begin
            failures++;
            $display("FAIL start: estado=%b Q=%0d, want 01 49", estado, Q);
        end
        sobe = 1'b1;
        tick();
        checks++;
        if (Q !== 7'd50) begin
            failures++;
            $display("FAIL climb_first: Q=%0d, want 50", Q);
        end
        repeat (48) tick();
        checks++;
        if (Q !== 7'd98 || fim_alto !== 1'b0 || estado !== 2'b01) begin
            failures++;
            $display("FAIL climb_98: Q=%0d fa=%b estado=%b, want 98 0 01", Q, fim_alto, estado);
        end
        tick();
        checks++;
        if (Q !== 7'd99 || fim_alto !== 1'b1 || estado !== 2'b10 || travado !== 1'b1) begin
            failures++;
            $display("FAIL climb_top: Q=%0d fa=%b estado=%b tr=%b, want 99 1 10 1",
                     Q, fim_alto, estado, travado);
        end
        sobe  = 1'b0;
        desce = 1'b1;
        repeat (3) tick();
        sobe = 1'b1;
        repeat (6) tick();
        sobe  = 1'b0;
        desce = 1'b0;
        checks++;
        if (Q !== 7'd99 || estado !== 2'b10) begin
            failures++;
            $display("FAIL top_frozen: Q=%0d estado=%b, want 99 10", Q, estado);
        end
    endtask

    task automatic test_descend();
        do_reset();
        start_game();
        desce = 1'b1;
        repeat (48) tick();
        checks++;
        if (Q !== 7'd1 || estado !== 2'b01) begin
            failures++;
            $display("FAIL descend_1: Q=%0d estado=%b, want 1 01", Q, estado);
        end
        tick();
        desce = 1'b0;
        checks++;
        if (Q !== 7'd0 || fim_baixo !== 1'b1 || travado !== 1'b1 || estado !== 2'b10) begin
            failures++;
            $display("FAIL descend_floor: Q=%0d fb=%b tr=%b estado=%b, want 0 1 1 10",
                     Q, fim_baixo, travado, estado);
        end
    endtask

    task automatic test_drift();
        do_reset();
        start_game();
        sobe = 1'b1;
        repeat (3) tick();
        sobe = 1'b0;
        repeat (3) tick();
        checks++;
        if (Q !== 7'd52) begin
            failures++;
            $display("FAIL drift_wait: Q=%0d, want 52", Q);
        end
        tick();
        checks++;
        if (Q !== 7'd51) begin
            failures++;
            $display("FAIL drift_4: Q=%0d, want 51", Q);
        end
        repeat (4) tick();
        checks++;
        if (Q !== 7'd50) begin
            failures++;
            $display("FAIL drift_8: Q=%0d, want 50", Q);
        end
        repeat (4) tick();
        checks++;
        if (Q !== 7'd49 || meio !== 1'b1) begin
            failures++;
            $display("FAIL drift_12: Q=%0d meio=%b, want 49 1", Q, meio);
        end
        repeat (9) tick();
        checks++;
        if (Q !== 7'd49 || estado !== 2'b01) begin
            failures++;
            $display("FAIL drift_settled: Q=%0d estado=%b, want 49 01", Q, estado);
        end
        desce = 1'b1;
        repeat (3) tick();
        desce = 1'b0;
        repeat (4) tick();
        checks++;
        if (Q !== 7'd47) begin
            failures++;
            $display("FAIL drift_up: Q=%0d, want 47", Q);
        end
    endtask

    task automatic test_drift_inputs();
        do_reset();
        start_game();
        sobe = 1'b1;
        repeat (2) tick();
        desce = 1'b1;
        repeat (3) tick();
        checks++;
        if (Q !== 7'd51) begin
            failures++;
            $display("FAIL both_high_wait: Q=%0d, want 51", Q);
        end
        tick();
        checks++;
        if (Q !== 7'd50) begin
            failures++;
            $display("FAIL both_high_drift: Q=%0d, want 50", Q);
        end
        sobe  = 1'b0;
        desce = 1'b0;
        repeat (2) tick();
        sobe = 1'b1;
        tick();
        sobe = 1'b0;
        repeat (3) tick();
        checks++;
        if (Q !== 7'd51) begin
            failures++;
            $display("FAIL pulse_restart_wait: Q=%0d, want 51", Q);
        end
        tick();
        checks++;
        if (Q !== 7'd50) begin
            failures++;
            $display("FAIL pulse_restart_drift: Q=%0d, want 50", Q);
        end
    endtask

    task automatic test_release_sync();
        do_reset();
        start_game();
        sobe = 1'b1;
        repeat (50) tick();
        sobe   = 1'b0;
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
        checks++;
        if (Q !== 7'd49 || estado !== 2'b00 || travado !== 1'b0) begin
            failures++;
            $display("FAIL release: Q=%0d estado=%b tr=%b, want 49 00 0", Q, estado, travado);
        end
        start_game();
        sobe = 1'b1;
        repeat (21) tick();
        checks++;
        if (Q !== 7'd70) begin
            failures++;
            $display("FAIL reach_70: Q=%0d, want 70", Q);
        end
        zera_s = 1'b1;
        inicia = 1'b1;
        tick();
        zera_s = 1'b0;
        inicia = 1'b0;
        checks++;
        if (Q !== 7'd49 || estado !== 2'b00) begin
            failures++;
            $display("FAIL sync_clear: Q=%0d estado=%b, want 49 00", Q, estado);
        end
        tick();
        sobe = 1'b0;
        checks++;
        if (Q !== 7'd49 || estado !== 2'b00) begin
            failures++;
            $display("FAIL after_clear: Q=%0d estado=%b, want 49 00", Q, estado);
        end
    endtask

    task automatic test_async_midstep();
        do_reset();
        start_game();
        sobe = 1'b1;
        repeat (5) tick();
        #2;
        zera_as = 1'b1;
        #1;
        checks++;
        if (Q !== 7'd49 || estado !== 2'b00) begin
            failures++;
            $display("FAIL async_midstep: Q=%0d estado=%b, want 49 00", Q, estado);
        end
        zera_as = 1'b0;
        sobe    = 1'b0;
    endtask

    // Reference: phase 0 parked, 1 playing, 2 locked; idle counts consecutive
    // cycles without a single-player push since the last move.
    int m_pos, m_phase, m_idle;

    task automatic test_random();
        int p_up, p_dn;
        int locks;
        do_reset();
        m_pos   = C;
        m_phase = 0;
        m_idle  = 0;
        locks   = 0;
        p_up    = 50;
        p_dn    = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 100 == 0) begin
                p_up = 10 + 40 * $urandom_range(0, 2);
                p_dn = 10 + 40 * $urandom_range(0, 2);
            end
            sobe   = ($urandom_range(0, 99) < p_up);
            desce  = ($urandom_range(0, 99) < p_dn);
            inicia = ($urandom_range(0, 15) == 0);
            zera_s = ($urandom_range(0, 127) == 0);

            if (zera_s) begin
                m_phase = 0;
                m_pos   = C;
                m_idle  = 0;
            end else if (m_phase == 0) begin
                m_pos  = C;
                m_idle = 0;
                if (inicia) m_phase = 1;
            end else if (m_phase == 1) begin
                if (sobe != desce) begin
                    m_idle = 0;
                    if (sobe) m_pos = (m_pos + 1 > M - 1) ? M - 1 : m_pos + 1;
                    else      m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                end else begin
                    m_idle++;
                    if (m_idle == DECAY) begin
                        m_idle = 0;
                        if (m_pos > C) m_pos--;
                        else if (m_pos < C) m_pos++;
                    end
                end
                if (m_pos == 0 || m_pos == M - 1) begin
                    m_phase = 2;
                    locks++;
                end
            end else begin
                if (inicia) begin
                    m_phase = 0;
                    m_pos   = C;
                    m_idle  = 0;
                end
            end

            tick();
            checks++;
            if (int'(Q) !== m_pos || int'(estado) !== m_phase
                || travado !== (m_phase == 2) || fim_alto !== (m_pos == M - 1)
                || fim_baixo !== (m_pos == 0) || meio !== (m_pos == C)) begin
                failures++;
                $display("FAIL random_cyc%0d: Q=%0d estado=%0d tr=%b fa=%b fb=%b meio=%b, want Q=%0d estado=%0d",
                         cyc, Q, estado, travado, fim_alto, fim_baixo, meio, m_pos, m_phase);
            end
        end
        sobe   = 1'b0;
        desce  = 1'b0;
        inicia = 1'b0;
        zera_s = 1'b0;
        $display("random run: %0d end locks seen", locks);
    endtask

    initial begin
        #3;
        test_reset();
        test_climb();
        test_descend();
        test_drift();
        test_drift_inputs();
        test_release_sync();
        test_async_midstep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
